// File: rtl/tawas_irom_resp_if.sv
// Tawas fetch bus plus program loader port, bundled for the instruction ROM responder.
`timescale 1ns/1ps
interface tawas_irom_resp_if;
   // Fetch side
   logic        ics;
   logic [23:0] iaddr;
   logic [31:0] idata;
   // Loader side (req/ack)
   logic        ld_req;
   logic        ld_we;
   logic [23:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_ack;
   logic [31:0] ld_rdata;
   // Out-of-bounds fetch status
   logic        oob_pulse;
   logic [15:0] oob_cnt;

   // Core fetch unit / boot agent side
   modport master (
      output ics, iaddr, ld_req, ld_we, ld_addr, ld_wdata,
      input  idata, ld_ack, ld_rdata, oob_pulse, oob_cnt
   );

   // Instruction memory side
   modport slave (
      input  ics, iaddr, ld_req, ld_we, ld_addr, ld_wdata,
      output idata, ld_ack, ld_rdata, oob_pulse, oob_cnt
   );
endinterface

// File: rtl/tawas_irom_resp.sv
// Instruction-memory responder: answers fetch strobes with one-cycle latency and
// lets a loader read/write program words in cycles where no fetch is issued.
`timescale 1ns/1ps
module tawas_irom_resp #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] HALT_WORD = 32'hC000_0000
) (
   input logic              clk,
   input logic              rst_n,
   tawas_irom_resp_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } ld_state_t;

   ld_state_t r_state;
   ld_state_t w_state_nxt;

   logic [31:0]       r_mem [DEPTH];
   logic [31:0]       r_idata;
   logic [31:0]       r_ld_rdata;
   logic              r_oob_pulse;
   logic [15:0]       r_oob_cnt;

   logic              w_fetch_backed;
   logic              w_ld_backed;
   logic [ADDR_W-1:0] w_fetch_idx;
   logic [ADDR_W-1:0] w_ld_idx;
   logic              w_ld_go;
   logic              w_ld_wr;
   logic              w_ld_rd;
   logic [ADDR_W-1:0] w_mem_idx;
   logic [31:0]       w_mem_rdata;
   logic              w_ld_ack;

   // Address decode: only the low ADDR_W bits are backed by storage.
   assign w_fetch_backed = (bus.iaddr[23:ADDR_W] == '0);
   assign w_ld_backed    = (bus.ld_addr[23:ADDR_W] == '0);
   assign w_fetch_idx    = bus.iaddr[ADDR_W-1:0];
   assign w_ld_idx       = bus.ld_addr[ADDR_W-1:0];

   // A loader access fires only from IDLE and only when no fetch owns the port.
   assign w_ld_go = (r_state == ST_IDLE) && bus.ld_req && !bus.ics;
   assign w_ld_wr = w_ld_go && bus.ld_we && w_ld_backed;
   assign w_ld_rd = w_ld_go && !bus.ld_we;

   // Single array port: the fetch address wins whenever ics is high.
   assign w_mem_idx   = bus.ics ? w_fetch_idx : w_ld_idx;
   assign w_mem_rdata = r_mem[w_mem_idx];

   // Program storage write port.
   // NOTE: the array has no reset so it maps onto plain RAM and survives a core reset.
   always_ff @(posedge clk) begin
      if (w_ld_wr) begin
         r_mem[w_mem_idx] <= bus.ld_wdata;
      end
   end

   // Fetch result register: updates on every strobe, holds otherwise.
   // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idata <= '0;
      end else if (bus.ics) begin
         r_idata <= w_fetch_backed ? w_mem_rdata : HALT_WORD;
      end
   end

   // Loader read data: updated only on a read access, held across writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ld_rdata <= '0;
      end else if (w_ld_rd) begin
         r_ld_rdata <= w_ld_backed ? w_mem_rdata : HALT_WORD;
      end
   end

   // Out-of-bounds fetch flag and saturating counter (fetches only).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oob_pulse <= 1'b0;
         r_oob_cnt   <= '0;
      end else begin
         r_oob_pulse <= bus.ics && !w_fetch_backed;
         if (bus.ics && !w_fetch_backed && (r_oob_cnt != 16'hFFFF)) begin
            r_oob_cnt <= r_oob_cnt + 16'd1;
         end
      end
   end

   // Loader FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Loader FSM next state: ACK always lasts exactly one cycle.
   // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_ld_go) w_state_nxt = ST_ACK;
         ST_ACK:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Loader FSM outputs: ack is a pure decode of the ACK state.
   always_comb begin
      w_ld_ack = 1'b0;
      if (r_state == ST_ACK) begin
         w_ld_ack = 1'b1;
      end
   end

   assign bus.idata     = r_idata;
   assign bus.ld_ack    = w_ld_ack;
   assign bus.ld_rdata  = r_ld_rdata;
   assign bus.oob_pulse = r_oob_pulse;
   assign bus.oob_cnt   = r_oob_cnt;

endmodule

// File: tb/tb_tawas_irom_resp.sv
// Bench for tawas_irom_resp: directed scenarios plus random fetch/loader traffic,
// all checked every cycle against a behavioural memory model.
`timescale 1ns/1ps
module tb_tawas_irom_resp;

   localparam int unsigned DEPTH     = 4096;
   localparam logic [31:0] HALT      = 32'hC000_0000;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic chk_en;

   tawas_irom_resp_if u_if ();

   tawas_irom_resp #(
      .ADDR_W    (12),
      .HALT_WORD (HALT)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_idata;
   logic [31:0] m_rdata;
   logic        m_ack;
   logic        m_pulse;
   logic [15:0] m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idata <= '0;
         m_rdata <= '0;
         m_ack   <= 1'b0;
         m_pulse <= 1'b0;
         m_cnt   <= '0;
      end else begin
         m_pulse <= 1'b0;
         if (u_if.ics) begin
            if (u_if.iaddr < DEPTH) begin
               m_idata <= m_mem[u_if.iaddr[11:0]];
            end else begin
               m_idata <= HALT;
               m_pulse <= 1'b1;
               if (m_cnt < 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            end
         end
         if (m_ack) begin
            m_ack <= 1'b0;
         end else if (u_if.ld_req && !u_if.ics) begin
            m_ack <= 1'b1;
            if (u_if.ld_we) begin
               if (u_if.ld_addr < DEPTH) m_mem[u_if.ld_addr[11:0]] <= u_if.ld_wdata;
            end else begin
               m_rdata <= (u_if.ld_addr < DEPTH) ? m_mem[u_if.ld_addr[11:0]] : HALT;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         check("idata",     u_if.idata,            m_idata);
         check("ld_ack",    32'(u_if.ld_ack),      32'(m_ack));
         check("ld_rdata",  u_if.ld_rdata,         m_rdata);
         check("oob_pulse", 32'(u_if.oob_pulse),   32'(m_pulse));
         check("oob_cnt",   32'(u_if.oob_cnt),     32'(m_cnt));
      end
   end

   // ---------------- stimulus helpers (entered and left at a falling edge) ----------------
   task automatic ld_op(input logic we, input logic [23:0] a, input logic [31:0] d, output int lat);
      u_if.ld_req   = 1'b1;
      u_if.ld_we    = we;
      u_if.ld_addr  = a;
      u_if.ld_wdata = d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!u_if.ld_ack && lat < 100);
      if (!u_if.ld_ack) check("ld_ack_timeout", 32'(u_if.ld_ack), 32'd1);
      u_if.ld_req = 1'b0;
   endtask

   task automatic fetch(input logic [23:0] a);
      u_if.ics   = 1'b1;
      u_if.iaddr = a;
      @(negedge clk);
      u_if.ics   = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic        req_active;
      logic [31:0] v;

      tests = 0;
      fails = 0;
      chk_en = 1'b0;
      rst_n = 1'b0;
      u_if.ics = 1'b0;
      u_if.iaddr = '0;
      u_if.ld_req = 1'b0;
      u_if.ld_we = 1'b0;
      u_if.ld_addr = '0;
      u_if.ld_wdata = '0;

      // 1: reset values, then quiet bus after release
      repeat (3) @(negedge clk);
      check("rst_idata",     u_if.idata,          32'h0);
      check("rst_ld_ack",    32'(u_if.ld_ack),    32'h0);
      check("rst_ld_rdata",  u_if.ld_rdata,       32'h0);
      check("rst_oob_pulse", 32'(u_if.oob_pulse), 32'h0);
      check("rst_oob_cnt",   32'(u_if.oob_cnt),   32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_idata",    u_if.idata,          32'h0);
      check("idle_oob_cnt",  32'(u_if.oob_cnt),   32'h0);

      // 2: loader write then fetch, idata held while ics=0
      ld_op(1'b1, 24'h000010, 32'h1234_5678, lat);
      check("wr_ack_latency", 32'(lat), 32'd1);
      @(negedge clk);
      check("ack_one_cycle", 32'(u_if.ld_ack), 32'h0);
      fetch(24'h000010);
      check("fetch_0x10", u_if.idata, 32'h1234_5678);
      repeat (2) @(negedge clk);
      check("fetch_0x10_held", u_if.idata, 32'h1234_5678);

      // 3: back-to-back fetches of 0..3
      for (int k = 0; k < 4; k++) ld_op(1'b1, 24'(k), 32'hA0 + 32'(k), lat);
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) check("stream_idata", u_if.idata, 32'hA0 + 32'(k - 1));
         u_if.ics   = (k < 4);
         u_if.iaddr = 24'(k);
         if (k < 4) @(negedge clk);
      end

      // 4: loader read stalled by 5 fetch cycles
      ld_op(1'b1, 24'h000020, 32'hDEAD_0020, lat);
      u_if.ics     = 1'b1;
      u_if.iaddr   = 24'h000002;
      u_if.ld_req  = 1'b1;
      u_if.ld_we   = 1'b0;
      u_if.ld_addr = 24'h000020;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_no_ack", 32'(u_if.ld_ack), 32'h0);
      end
      check("stall_idata", u_if.idata, 32'hA2);
      u_if.ics = 1'b0;
      @(negedge clk);
      check("stall_ack", 32'(u_if.ld_ack), 32'h1);
      check("stall_rdata", u_if.ld_rdata, 32'hDEAD_0020);
      u_if.ld_req = 1'b0;

      // 5: out-of-bounds fetch and loader write
      fetch(24'h001000);
      check("oob_idata", u_if.idata, 32'hC000_0000);
      check("oob_pulse", 32'(u_if.oob_pulse), 32'h1);
      check("oob_cnt_1", 32'(u_if.oob_cnt), 32'h1);
      ld_op(1'b1, 24'h001000, 32'h5555_5555, lat);
      check("oob_wr_latency", 32'(lat), 32'd1);
      fetch(24'h000000);
      check("oob_wr_no_alias", u_if.idata, 32'hA0);
      check("oob_cnt_still_1", 32'(u_if.oob_cnt), 32'h1);

      // 6: reset during the ack cycle suppresses the ack, array survives
      u_if.ld_req  = 1'b1;
      u_if.ld_we   = 1'b0;
      u_if.ld_addr = 24'h000010;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      u_if.ld_req = 1'b0;
      @(negedge clk);
      check("rst_kill_ack", 32'(u_if.ld_ack), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_kill_ack2", 32'(u_if.ld_ack), 32'h0);
      check("rst_rdata", u_if.ld_rdata, 32'h0);
      fetch(24'h000010);
      check("mem_survives_rst", u_if.idata, 32'h1234_5678);

      // random traffic over a preloaded window plus unbacked addresses
      for (int k = 0; k < 64; k++) ld_op(1'b1, 24'(k), $urandom, lat);
      req_active = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         u_if.ics   = ($urandom_range(0, 1) == 1);
         u_if.iaddr = ($urandom_range(0, 9) == 0) ? 24'($urandom_range(32'h1000, 32'hFF_FFFF))
                                                  : 24'($urandom_range(0, 63));
         if (req_active && u_if.ld_ack) begin
            u_if.ld_req = 1'b0;
            req_active  = 1'b0;
         end else if (!req_active && $urandom_range(0, 3) == 0) begin
            v = $urandom;
            u_if.ld_req   = 1'b1;
            u_if.ld_we    = v[0];
            u_if.ld_addr  = v[4] ? 24'($urandom_range(32'h1000, 32'hFF_FFFF))
                                 : 24'($urandom_range(0, 63));
            u_if.ld_wdata = $urandom;
            req_active    = 1'b1;
         end
         @(negedge clk);
      end
      u_if.ics    = 1'b0;
      u_if.ld_req = 1'b0;
      repeat (3) @(negedge clk);

      // saturation of the out-of-bounds counter
      u_if.ics   = 1'b1;
      u_if.iaddr = 24'h80_0000;
      repeat (70000) @(negedge clk);
      u_if.ics = 1'b0;
      @(negedge clk);
      check("oob_cnt_sat", 32'(u_if.oob_cnt), 32'h0000_FFFF);
      check("oob_pulse_clear", 32'(u_if.oob_pulse), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
